// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-scheduling engine: FSM state encoding and
// normalisation of the run-time key length.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RD_I   = 4'd1,
    ST_WT_I   = 4'd2,
    ST_CALC_J = 4'd3,
    ST_RD_J   = 4'd4,
    ST_WT_J   = 4'd5,
    ST_WR_J   = 4'd6,
    ST_WR_I   = 4'd7,
    ST_DONE   = 4'd8
  } ksa_state_t;

  // A zero or oversize length means "use the whole key bus".
  function automatic int unsigned eff_key_len(input int unsigned len,
                                               input int unsigned max_len);
    int unsigned r;
    if ((len == 32'd0) || (len > max_len)) r = max_len;
    else r = len;
    return r;
  endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Holds the latched key and effective length for one KSA run and presents the
// key byte selected by a wrapping index (byte 0 is the most significant byte).
module rc4_key_byte_sel
  import rc4_pkg::*;
#(
  parameter int MAX_KEY_BYTES = 3,
  parameter int KLEN_W        = $clog2(MAX_KEY_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       advance,
  input  logic                       clear,
  input  logic [8*MAX_KEY_BYTES-1:0] key,
  input  logic [KLEN_W-1:0]          key_len,
  output logic [7:0]                 key_byte
);

  logic [8*MAX_KEY_BYTES-1:0] key_r;
  logic [KLEN_W-1:0]          len_r;
  logic [KLEN_W-1:0]          kidx_r;

  // Key/length capture on load and the wrapping key index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r  <= '0;
      len_r  <= '0;
      kidx_r <= '0;
    end else if (load) begin
      key_r  <= key;
      len_r  <= KLEN_W'(eff_key_len(32'(key_len), MAX_KEY_BYTES));
      kidx_r <= '0;
    end else if (clear) begin
      kidx_r <= '0;
    end else if (advance) begin
      kidx_r <= (kidx_r == (len_r - KLEN_W'(1))) ? '0 : (kidx_r + KLEN_W'(1));
    end else begin
      kidx_r <= kidx_r;
    end
  end

  assign key_byte = key_r[8*(MAX_KEY_BYTES-1-int'(kidx_r)) +: 8];

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: permutes an identity S-array held in an external
// single-port synchronous RAM, seven cycles per index, with a start/done handshake.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int MAX_KEY_BYTES = 3,
  parameter int KLEN_W        = $clog2(MAX_KEY_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [8*MAX_KEY_BYTES-1:0] key,
  input  logic [KLEN_W-1:0]          key_len,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [ADDR_W-1:0]          mem_wdata,
  output logic                       mem_we,
  input  logic [ADDR_W-1:0]          mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  ksa_state_t        state_r, state_n_s;
  logic [ADDR_W-1:0] i_r, j_r, si_r, sj_r;
  logic [ADDR_W-1:0] i_n_s, j_n_s, si_n_s, sj_n_s;
  logic              load_s, advance_s, clear_s;
  logic [7:0]        key_byte_s;
  logic              busy_n_s, done_n_s, we_n_s;
  logic [ADDR_W-1:0] addr_n_s, wdata_n_s;

  rc4_key_byte_sel #(
    .MAX_KEY_BYTES(MAX_KEY_BYTES),
    .KLEN_W       (KLEN_W)
  ) u_key_sel (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_s),
    .advance (advance_s),
    .clear   (clear_s),
    .key     (key),
    .key_len (key_len),
    .key_byte(key_byte_s)
  );

  // Next state, datapath updates, and output decode of the next state so the
  // RAM interface comes straight from flops.
  always_comb begin
    state_n_s = state_r;
    i_n_s     = i_r;
    j_n_s     = j_r;
    si_n_s    = si_r;
    sj_n_s    = sj_r;
    load_s    = 1'b0;
    advance_s = 1'b0;
    clear_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n_s = ST_RD_I;
          i_n_s     = '0;
          j_n_s     = '0;
          load_s    = 1'b1;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_RD_I: state_n_s = ST_WT_I;
      ST_WT_I: begin
        si_n_s    = mem_rdata;
        state_n_s = ST_CALC_J;
      end
      ST_CALC_J: begin
        j_n_s     = j_r + si_r + ADDR_W'(key_byte_s);
        state_n_s = ST_RD_J;
      end
      ST_RD_J: state_n_s = ST_WT_J;
      ST_WT_J: begin
        sj_n_s    = mem_rdata;
        state_n_s = ST_WR_J;
      end
      ST_WR_J: state_n_s = ST_WR_I;
      ST_WR_I: begin
        if (i_r == LAST_IDX) begin
          state_n_s = ST_DONE;
        end else begin
          i_n_s     = i_r + ADDR_W'(1);
          advance_s = 1'b1;
          state_n_s = ST_RD_I;
        end
      end
      ST_DONE: begin
        clear_s   = 1'b1;
        state_n_s = ST_IDLE;
      end
      default: state_n_s = ST_IDLE;
    endcase

    busy_n_s  = (state_n_s != ST_IDLE);
    done_n_s  = (state_n_s == ST_DONE);
    addr_n_s  = '0;
    wdata_n_s = '0;
    we_n_s    = 1'b0;
    case (state_n_s)
      ST_RD_I, ST_WT_I: addr_n_s = i_n_s;
      ST_RD_J, ST_WT_J: addr_n_s = j_n_s;
      ST_WR_J: begin
        addr_n_s  = j_n_s;
        wdata_n_s = si_n_s;
        we_n_s    = 1'b1;
      end
      ST_WR_I: begin
        addr_n_s  = i_n_s;
        wdata_n_s = sj_n_s;
        we_n_s    = 1'b1;
      end
      default: addr_n_s = '0;
    endcase
  end

  // State, index/swap registers and registered RAM/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      i_r       <= '0;
      j_r       <= '0;
      si_r      <= '0;
      sj_r      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      i_r       <= i_n_s;
      j_r       <= j_n_s;
      si_r      <= si_n_s;
      sj_r      <= sj_n_s;
      busy      <= busy_n_s;
      done      <= done_n_s;
      mem_addr  <= addr_n_s;
      mem_wdata <= wdata_n_s;
      mem_we    <= we_n_s;
    end
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Scoreboard bench for rc4_ksa_engine: a 256-entry instance (3-byte key bus) and
// a 16-entry instance (5-byte key bus), each with its own synchronous RAM model.
module tb_rc4_ksa_engine;

  localparam int MK1 = 3;
  localparam int KW1 = $clog2(MK1 + 1);
  localparam int MK2 = 5;
  localparam int KW2 = $clog2(MK2 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int            id;
    int            start_cyc;
    int            lat;
    logic [2047:0] s;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   done_cnt1 = 0;
  int   pushed1 = 0;

  // ---------------- instance 1: ADDR_W=8, MAX_KEY_BYTES=3
  logic            start1, busy1, done1, we1, init1;
  logic [23:0]     key1;
  logic [KW1-1:0]  klen1;
  logic [7:0]      addr1, wdata1, rdata1;
  logic [7:0]      ram1 [256];

  rc4_ksa_engine #(.ADDR_W(8), .MAX_KEY_BYTES(MK1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .key(key1), .key_len(klen1),
    .busy(busy1), .done(done1), .mem_addr(addr1), .mem_wdata(wdata1),
    .mem_we(we1), .mem_rdata(rdata1)
  );

  always @(posedge clk) begin
    if (init1) for (int k = 0; k < 256; k++) ram1[k] <= 8'(k);
    else if (we1) ram1[addr1] <= wdata1;
    rdata1 <= ram1[addr1];
  end

  // ---------------- instance 2: ADDR_W=4, MAX_KEY_BYTES=5
  logic            start2, busy2, done2, we2, init2;
  logic [39:0]     key2;
  logic [KW2-1:0]  klen2;
  logic [3:0]      addr2, wdata2, rdata2;
  logic [3:0]      ram2 [16];

  rc4_ksa_engine #(.ADDR_W(4), .MAX_KEY_BYTES(MK2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .key(key2), .key_len(klen2),
    .busy(busy2), .done(done2), .mem_addr(addr2), .mem_wdata(wdata2),
    .mem_we(we2), .mem_rdata(rdata2)
  );

  always @(posedge clk) begin
    if (init2) for (int k = 0; k < 16; k++) ram2[k] <= 4'(k);
    else if (we2) ram2[addr2] <= wdata2;
    rdata2 <= ram2[addr2];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // Reference KSA on an identity array of 'depth' entries.
  function automatic logic [2047:0] ksa_model(input logic [63:0] key, input int bus_bytes,
                                              input int len, input int depth);
    int s [256];
    int j, t, kb;
    logic [2047:0] r;
    for (int k = 0; k < 256; k++) s[k] = k;
    j = 0;
    for (int i = 0; i < depth; i++) begin
      kb = 0;
      kb[7:0] = key[8*(bus_bytes-1-(i%len)) +: 8];
      j = (j + s[i] + kb) % depth;
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    r = '0;
    for (int k = 0; k < depth; k++) r[8*k +: 8] = 8'(s[k]);
    return r;
  endfunction

  // Monitor for instance 1: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    int   bad, first;
    if (rst_n && done1) begin
      done_cnt1++;
      if (q1.size() == 0) begin
        chk("unexpected_done1", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk($sformatf("latency1_run%0d", e.id), 32'(cyc - e.start_cyc), 32'(e.lat));
        bad = 0; first = -1;
        for (int k = 0; k < 256; k++)
          if (ram1[k] !== e.s[8*k +: 8]) begin bad++; if (first < 0) first = k; end
        checks++;
        if (bad != 0) begin
          failures++;
          $display("FAIL ram1_run%0d bad_entries=%0d at idx %0d got=%0h required=%0h",
                   e.id, bad, first, ram1[first], e.s[8*first +: 8]);
        end
      end
    end
  end

  // Monitor for instance 2.
  always @(negedge clk) begin
    exp_t e;
    int   bad, first;
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        chk($sformatf("latency2_run%0d", e.id), 32'(cyc - e.start_cyc), 32'(e.lat));
        bad = 0; first = -1;
        for (int k = 0; k < 16; k++)
          if ({4'h0, ram2[k]} !== e.s[8*k +: 8]) begin bad++; if (first < 0) first = k; end
        checks++;
        if (bad != 0) begin
          failures++;
          $display("FAIL ram2_run%0d bad_entries=%0d at idx %0d got=%0h required=%0h",
                   e.id, bad, first, ram2[first], e.s[8*first +: 8]);
        end
      end
    end
  end

  // Initialise the RAM, issue start, push the expectation, then scramble the key inputs.
  task automatic go1(input int id, input logic [23:0] k, input logic [KW1-1:0] kl,
                     input int eff_len, input bit expect_done, output int s);
    exp_t e;
    @(negedge clk); init1 = 1'b1;
    @(negedge clk); init1 = 1'b0;
    key1 = k; klen1 = kl; start1 = 1'b1; s = cyc;
    if (expect_done) begin
      e.id = id; e.start_cyc = s; e.lat = 1793;
      e.s = ksa_model({40'h0, k}, MK1, eff_len, 256);
      q1.push_back(e);
      pushed1++;
    end
    @(negedge clk); start1 = 1'b0;
    key1 = ~k; klen1 = KW1'(1);
  endtask

  task automatic go2(input int id, input logic [39:0] k, input logic [KW2-1:0] kl,
                     input int eff_len);
    exp_t e;
    @(negedge clk); init2 = 1'b1;
    @(negedge clk); init2 = 1'b0;
    key2 = k; klen2 = kl; start2 = 1'b1;
    e.id = id; e.start_cyc = cyc; e.lat = 113;
    e.s = ksa_model({24'h0, k}, MK2, eff_len, 16);
    q2.push_back(e);
    @(negedge clk); start2 = 1'b0;
    key2 = ~k; klen2 = KW2'(2);
  endtask

  task automatic wait_q1(input int budget);
    int n = 0;
    while (q1.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk("wait_done1_timeout", 32'(q1.size()), 32'd0);
    q1.delete();
  endtask

  task automatic wait_q2(input int budget);
    int n = 0;
    while (q2.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk("wait_done2_timeout", 32'(q2.size()), 32'd0);
    q2.delete();
  endtask

  initial begin
    int s;
    int ps [256];
    int pi, pj, pt;
    logic [31:0] ks;

    rst_n = 1'b0;
    start1 = 1'b0; init1 = 1'b0; key1 = '0; klen1 = '0;
    start2 = 1'b0; init2 = 1'b0; key2 = '0; klen2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_we1", 32'(we1), 32'd0);
    chk("rst_addr1", 32'(addr1), 32'd0);
    chk("rst_wdata1", 32'(wdata1), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    rst_n = 1'b1;

    // Key 01 02 03: first two swaps checked by hand, then the full permutation.
    go1(1, 24'h010203, KW1'(3), 3, 1'b1, s);
    repeat (7) @(negedge clk);
    chk("idx0_S0", 32'(ram1[0]), 32'h1);
    chk("idx0_S1", 32'(ram1[1]), 32'h0);
    chk("busy_in_run", 32'(busy1), 32'd1);
    repeat (7) @(negedge clk);
    chk("idx1_S1", 32'(ram1[1]), 32'h3);
    chk("idx1_S3", 32'(ram1[3]), 32'h0);
    wait_q1(2500);

    // "Key": PRGA over the resulting array gives the well-known keystream.
    go1(2, 24'h4B6579, KW1'(3), 3, 1'b1, s);
    wait_q1(2500);
    for (int k = 0; k < 256; k++) ps[k] = int'(ram1[k]);
    pi = 0; pj = 0; ks = '0;
    for (int n = 0; n < 4; n++) begin
      pi = (pi + 1) % 256;
      pj = (pj + ps[pi]) % 256;
      pt = ps[pi]; ps[pi] = ps[pj]; ps[pj] = pt;
      ks = {ks[23:0], 8'(ps[(ps[pi] + ps[pj]) % 256])};
    end
    chk("keystream_Key", ks, 32'hEB9F7781);

    // One-byte key, then key_len=0 which must behave as the full three bytes.
    go1(3, 24'hAA0000, KW1'(1), 1, 1'b1, s);
    wait_q1(2500);
    go1(4, 24'hAA0000, KW1'(0), 3, 1'b1, s);
    wait_q1(2500);

    // Reset mid-run: at cyc=s+504 the engine is in a write state.
    go1(5, 24'h010203, KW1'(3), 3, 1'b0, s);
    repeat (503) @(negedge clk);
    chk("pre_reset_we", 32'(we1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_we", 32'(we1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    go1(6, 24'h010203, KW1'(3), 3, 1'b1, s);
    wait_q1(2500);

    // Start pulses while busy are ignored.
    go1(7, 24'h0A0B0C, KW1'(3), 3, 1'b1, s);
    repeat (9) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (589) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    wait_q1(2500);
    repeat (30) @(negedge clk);
    chk("done_pulse_count", 32'(done_cnt1), 32'(pushed1));

    // 16-entry instance, 5-byte key, bytes truncated to 4 bits.
    go2(8, 40'h0123456789, KW2'(5), 5);
    wait_q2(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
